// File: rtl/regfile_wq.sv
// Purpose : 16 x WIDTH register array fed by an in-order write queue, with a per-register pending bitmap.
// Latency : a write accepted at edge N commits at the earliest on edge N+1 (no bypass into the array).
// Backpress: o_wr_ready drops while the queue holds DEPTH entries; i_commit_en=0 holds the queue head.
//
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_wr_valid / o_wr_ready / i_wr_addr / i_wr_data : handshaked write port into the queue
//   i_commit_en : lets the queue head commit into the array this cycle
//   i_flush     : drops all queued, uncommitted writes (wins over push and commit)
//   o_r0..o_r15 : registered architectural contents, feeding the downstream read-select mux
//   o_pending   : bit k set while any queued entry targets register k
//   o_q_count   : number of occupied queue entries
// Optional feature macro: REGFILE_ZERO_R0_EN (register 0 hardwired to zero, pending[0] forced low).
module regfile_wq #(
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_wr_valid,
   output logic             o_wr_ready,
   input  logic [3:0]       i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_commit_en,
   input  logic             i_flush,
   output logic [WIDTH-1:0] o_r0,
   output logic [WIDTH-1:0] o_r1,
   output logic [WIDTH-1:0] o_r2,
   output logic [WIDTH-1:0] o_r3,
   output logic [WIDTH-1:0] o_r4,
   output logic [WIDTH-1:0] o_r5,
   output logic [WIDTH-1:0] o_r6,
   output logic [WIDTH-1:0] o_r7,
   output logic [WIDTH-1:0] o_r8,
   output logic [WIDTH-1:0] o_r9,
   output logic [WIDTH-1:0] o_r10,
   output logic [WIDTH-1:0] o_r11,
   output logic [WIDTH-1:0] o_r12,
   output logic [WIDTH-1:0] o_r13,
   output logic [WIDTH-1:0] o_r14,
   output logic [WIDTH-1:0] o_r15,
   output logic [15:0]      o_pending,
   output logic [CW-1:0]    o_q_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Architectural state
   logic [WIDTH-1:0] r_regs [16];

   // Write queue: circular buffer, r_count separates full from empty
   logic [3:0]       r_q_addr [DEPTH];
   logic [WIDTH-1:0] r_q_data [DEPTH];
   logic [DEPTH-1:0] r_q_vld;
   logic [AW-1:0]    r_head;
   logic [AW-1:0]    r_tail;
   logic [CW-1:0]    r_count;
   logic [15:0]      r_pending;

   logic             w_wr_ready;
   logic             w_push;
   logic             w_pop;
   logic             w_head_wr;
   logic [3:0]       w_head_addr;
   logic [WIDTH-1:0] w_head_data;
   logic [DEPTH-1:0] w_vld_nxt;
   logic [15:0]      w_pending_nxt;

   // Ready depends on occupancy only, never on i_wr_valid.
   assign w_wr_ready  = (r_count != CW'(DEPTH));
   // Flush suppresses both sides of the queue in its cycle.
   assign w_push      = i_wr_valid & w_wr_ready & ~i_flush;
   assign w_pop       = (r_count != '0) & i_commit_en & ~i_flush;
   assign w_head_addr = r_q_addr[r_head];
   assign w_head_data = r_q_data[r_head];

`ifdef REGFILE_ZERO_R0_EN
   // Address-0 entries still occupy a slot and a commit, they just never land.
   assign w_head_wr = w_pop & (w_head_addr != 4'd0);
`else
   assign w_head_wr = w_pop;
`endif

   // Slot validity after this edge. Push and pop never hit the same slot:
   // a pop needs a non-empty queue and a push needs a non-full one, so with
   // both active the head and tail differ.
   always_comb begin
      w_vld_nxt = r_q_vld;
      if (i_flush) begin
         w_vld_nxt = '0;
      end else begin
         if (w_pop)  w_vld_nxt[r_head] = 1'b0;
         if (w_push) w_vld_nxt[r_tail] = 1'b1;
      end
   end

   // Pending bitmap built from the post-edge queue contents so that, once
   // registered, it lines up with o_q_count.
   always_comb begin
      w_pending_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_vld_nxt[i]) begin
            if (w_push && (r_tail == AW'(i)))
               w_pending_nxt[i_wr_addr] = 1'b1;
            else
               w_pending_nxt[r_q_addr[i]] = 1'b1;
         end
      end
`ifdef REGFILE_ZERO_R0_EN
      w_pending_nxt[0] = 1'b0;
`endif
   end

   // Queue control and storage
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_q_vld   <= '0;
         r_pending <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_q_addr[i] <= '0;
            r_q_data[i] <= '0;
         end
      end else begin
         r_q_vld   <= w_vld_nxt;
         r_pending <= w_pending_nxt;
         if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) begin
               r_q_addr[r_tail] <= i_wr_addr;
               r_q_data[r_tail] <= i_wr_data;
               r_tail           <= r_tail + 1'b1;
            end
            if (w_pop)
               r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // Register array: changes only on a commit or reset
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         for (int i = 0; i < 16; i++)
            r_regs[i] <= '0;
      end else if (w_head_wr) begin
         r_regs[w_head_addr] <= w_head_data;
      end
   end

   assign o_wr_ready = w_wr_ready;
   assign o_pending  = r_pending;
   assign o_q_count  = r_count;

   assign o_r0  = r_regs[0];
   assign o_r1  = r_regs[1];
   assign o_r2  = r_regs[2];
   assign o_r3  = r_regs[3];
   assign o_r4  = r_regs[4];
   assign o_r5  = r_regs[5];
   assign o_r6  = r_regs[6];
   assign o_r7  = r_regs[7];
   assign o_r8  = r_regs[8];
   assign o_r9  = r_regs[9];
   assign o_r10 = r_regs[10];
   assign o_r11 = r_regs[11];
   assign o_r12 = r_regs[12];
   assign o_r13 = r_regs[13];
   assign o_r14 = r_regs[14];
   assign o_r15 = r_regs[15];

endmodule

// File: doc/regfile_wq.md
Name: regfile_wq

Overview:
- 16 x 16-bit general register array with a buffered, handshaked write port.
- Sits directly upstream of the 16:1 read-select mux; drives the mux's r0..r15 data inputs.
- Writeback results enter a small in-order write queue and commit to the array one per cycle.
- A per-register pending bitmap lets control logic detect read-after-write hazards.

Parameters:
- WIDTH, 16, data width of each register and of wr_data.
- DEPTH, 2, write-queue entries; power of two, 2..8.
- CW, $clog2(DEPTH+1), width of q_count (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- wr_valid  input  1  write request present.
- wr_ready  output  1  queue can accept a write this cycle.
- wr_addr  input  4  destination register index.
- wr_data  input  WIDTH  write data.
- commit_en  input  1  allows the queue head to commit this cycle.
- flush  input  1  synchronously discards all queued, uncommitted writes.
- r0..r15  output  WIDTH each  current architectural register contents (registered).
- pending  output  16  bit k=1 while any queued entry targets register k.
- q_count  output  CW  number of occupied queue entries.

Behaviour:
- Reset (reset=0, asynchronous): r0..r15=0, queue empty, q_count=0, pending=0, wr_ready=1. Any in-flight writes are lost.
- wr_ready = (q_count != DEPTH), derived combinationally from state only, never from wr_valid.
- Push: wr_valid & wr_ready at a rising edge enqueues {wr_addr, wr_data} at the tail.
- Commit: q_count!=0 & commit_en at a rising edge writes the head entry into register head.addr and pops it.
- Push and pop in the same cycle are legal:
  - q_count is unchanged.
  - If the queue was full, wr_ready is already 0, so no push occurs; there is no pass-through.
- Latency: a write accepted at edge N into an empty queue, with commit_en=1 at edge N+1, is visible on rK after edge N+1. There is no same-cycle bypass.
- Ordering: strict FIFO. Multiple entries to the same address commit in order, so the last accepted value wins.
- pending:
  - Recomputed every cycle from the valid queue entries (OR of one-hot decodes), then registered so it aligns with q_count.
  - A bit clears in the cycle after its last entry commits.
- flush=1 at a rising edge:
  - Empties the queue (q_count=0, pending=0).
  - Has priority over both push and commit in that cycle: neither occurs, and the array is unchanged.
  - wr_ready returns to 1 in the next cycle.
- commit_en=0 holds the queue. Pushes continue until full; the array does not change.
- Pointer wrap: head and tail are log2(DEPTH)-bit counters wrapping modulo DEPTH; q_count disambiguates full from empty.
- r0..r15 change only on commit or reset; they are never X after reset.

Optional Feature:
- Macro: REGFILE_ZERO_R0_EN.
- Defined:
  - Register 0 is hardwired to 0.
  - Writes targeting address 0 are accepted and queued normally and consume a commit slot, but they do not modify r0.
  - pending[0] is always 0.
- Undefined: register 0 is an ordinary writable register.

Test Plan:
- Reset mid-operation: two writes queued, commit_en=0, then reset=0 for 1 cycle -> r0..r15=0, q_count=0, pending=0, wr_ready=1, with the asynchronous effect visible before the next clk edge.
- Single write (addr 5, data 16'hBEEF), commit_en=1 -> q_count=1 and pending[5]=1 after edge 1; r5=16'hBEEF, pending=0 and q_count=0 after edge 2.
- Fill and stall: commit_en=0, push addr 3 data 16'h0011 and addr 7 data 16'h0022 -> q_count=2 and wr_ready=0; a third wr_valid is ignored. Raising commit_en yields r3=16'h0011 one edge later, then r7=16'h0022 the edge after.
- Same-address ordering: push addr 9 data 16'h1111 then addr 9 data 16'h2222 -> pending[9] stays 1 until the second commit; final r9=16'h2222.
- Simultaneous push and pop with q_count=1 and commit_en=1 -> q_count stays 1, the head commits, and the new entry becomes the head.
- Flush with q_count=2 (addr 2, addr 4) and wr_valid=1 in the same cycle -> q_count=0, pending=0, r2 and r4 unchanged, and the new write is not accepted.
